// File: rtl/regfile_defs.sv
// regfile_defs
//   Shared constants for the register-file writeback path.
//   ADDR_W / DATA_W / NREGS : default register file geometry (8 x 16).
//   req_id_e                : requester identifiers (REQ_A = ALU, REQ_B = load unit).
package regfile_defs;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 16;
    localparam int NREGS  = 8;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
//   Two-way writeback arbiter. Same-cycle (combinational) grant.
//   Default build: round-robin on ties; the requester that did not win most
//   recently is preferred. last_grant resets to REQ_B so A wins the first tie.
//   Build macro WB_ARB_FIXED_PRIO_EN: fixed priority, A always beats B; the
//   last_grant register is still maintained but does not affect the decision.
// Ports
//   clk          in   clock
//   rst          in   synchronous active-high reset
//   req[1:0]     in   request vector, bit 0 = A, bit 1 = B
//   grant_taken  in   a grant occurred this cycle (updates last_grant)
//   gnt[1:0]     out  one-hot grant, same bit order as req
//   last_grant   out  id of the most recent winner (0 = A, 1 = B)
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       grant_taken,
    output logic [1:0] gnt,
    output logic       last_grant
);
    import regfile_defs::*;

    req_id_e last_grant_q;
    req_id_e last_grant_d;

    always_comb begin
        gnt = req;
`ifdef WB_ARB_FIXED_PRIO_EN
        if (req == 2'b11) begin
            gnt = 2'b01;
        end
`else
        if (req == 2'b11) begin
            gnt = (last_grant_q == REQ_B) ? 2'b01 : 2'b10;
        end
`endif
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (grant_taken) begin
            last_grant_d = gnt[1] ? REQ_B : REQ_A;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= REQ_B;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign last_grant = last_grant_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single register-file write port between requester A (ALU) and
//   requester B (load unit), keeps a per-register busy scoreboard (issue sets,
//   commit clears) and drives the write port from registered outputs.
//   Optional build macro: WB_ARB_FIXED_PRIO_EN (fixed A-over-B priority,
//   handled inside rr_arb2). Scoreboard and latency are identical in both builds.
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   iss_valid/iss_addr        reservation request from decode
//   iss_ready                 reservation accepted (combinational)
//   a_valid/a_addr/a_data     requester A write; a_ready = granted this cycle
//   b_valid/b_addr/b_data     requester B write; b_ready = granted this cycle
//   wr_en/wr_addr/wr_data     register file write port, one cycle after grant
//   busy[NREGS-1:0]           scoreboard, bit i = register i has a write outstanding
//   wb_err                    sticky: a grant hit a register that was not reserved
module regfile_wb_arbiter #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 16,
    parameter int NREGS  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic              iss_ready,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [NREGS-1:0]  busy,
    output logic              wb_err
);
    import regfile_defs::*;

    logic [1:0]        req;
    logic [1:0]        gnt;
    logic              grant_any;
    logic              last_grant;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_data;

    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_d;
    logic [NREGS-1:0]  set_vec;
    logic [NREGS-1:0]  clr_vec;
    logic              err_q;
    logic              err_d;

    assign req       = {b_valid, a_valid};
    assign grant_any = |gnt;

    rr_arb2 u_arb (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant_taken (grant_any),
        .gnt         (gnt),
        .last_grant  (last_grant)
    );

    assign a_ready    = gnt[REQ_A];
    assign b_ready    = gnt[REQ_B];
    assign grant_addr = gnt[REQ_B] ? b_addr : a_addr;
    assign grant_data = gnt[REQ_B] ? b_data : a_data;

    // Uses the registered busy bit, so a register being committed this cycle
    // still stalls its reissue until the next cycle.
    assign iss_ready = iss_valid & ~busy_q[iss_addr];

    // Per-register set/clear decode. Set is applied after clear so a
    // simultaneous reserve and commit of the same register leaves it busy.
    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_sb
            assign set_vec[gi] = iss_ready && (iss_addr == ADDR_W'(gi));
            assign clr_vec[gi] = wr_en_q && (wr_addr_q == ADDR_W'(gi));
        end
    endgenerate

    assign busy_d = (busy_q & ~clr_vec) | set_vec;
    assign err_d  = err_q | (grant_any & ~busy_q[grant_addr]);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            wr_en_q <= grant_any;
            if (grant_any) begin
                wr_addr_q <= grant_addr;
                wr_data_q <= grant_data;
            end
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign wb_err  = err_q;

    // The arbiter's history must record the winner of every grant.
    a_last_grant_tracks : assert property (@(posedge clk) disable iff (rst)
        grant_any |=> (last_grant == $past(gnt[REQ_B])));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        iss_valid;
    logic [2:0]  iss_addr;
    logic        iss_ready;
    logic        a_valid;
    logic [2:0]  a_addr;
    logic [15:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [2:0]  b_addr;
    logic [15:0] b_data;
    logic        b_ready;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [7:0]  busy;
    logic        wb_err;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .iss_ready (iss_ready),
        .a_valid   (a_valid),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .wb_err    (wb_err)
    );

    typedef struct {
        logic        rst;
        logic        iv;
        logic [2:0]  ia;
        logic        av;
        logic [2:0]  aa;
        logic [15:0] ad;
        logic        bv;
        logic [2:0]  ba;
        logic [15:0] bd;
        logic        eir;
        logic        ear;
        logic        ebr;
        logic        ewe;
        logic [2:0]  ewa;
        logic [15:0] ewd;
        logic [7:0]  ebusy;
        logic        eerr;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic add(
        input logic rst_v, input logic iv, input logic [2:0] ia,
        input logic av, input logic [2:0] aa, input logic [15:0] ad,
        input logic bv, input logic [2:0] ba, input logic [15:0] bd,
        input logic eir, input logic ear, input logic ebr,
        input logic ewe, input logic [2:0] ewa, input logic [15:0] ewd,
        input logic [7:0] ebusy, input logic eerr);
        vec_t v;
        v.rst = rst_v; v.iv = iv; v.ia = ia;
        v.av = av; v.aa = aa; v.ad = ad;
        v.bv = bv; v.ba = ba; v.bd = bd;
        v.eir = eir; v.ear = ear; v.ebr = ebr;
        v.ewe = ewe; v.ewa = ewa; v.ewd = ewd;
        v.ebusy = ebusy; v.eerr = eerr;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s vec=%0d got=%h expected=%h", nm, idx, act, exp);
        end
    endtask

    task automatic drive_idle();
        iss_valid = 1'b0; iss_addr = 3'd0;
        a_valid = 1'b0; a_addr = 3'd0; a_data = 16'h0;
        b_valid = 1'b0; b_addr = 3'd0; b_data = 16'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [15:0] seen;
        logic seen_we;
        logic done;

        // ---- vector table ----
        // Test 1: reset state, reserve r3, A writes r3
        add(1'b0, 1'b0,3'd0, 1'b0,3'd0,16'h0, 1'b0,3'd0,16'h0, 1'b0,1'b0,1'b0, 1'b0,3'd0,16'h0, 8'h00,1'b0);
        add(1'b0, 1'b1,3'd3, 1'b0,3'd0,16'h0, 1'b0,3'd0,16'h0, 1'b1,1'b0,1'b0, 1'b0,3'd0,16'h0, 8'h00,1'b0);
        add(1'b0, 1'b0,3'd0, 1'b1,3'd3,16'h1234, 1'b0,3'd0,16'h0, 1'b0,1'b1,1'b0, 1'b0,3'd0,16'h0, 8'h08,1'b0);
        add(1'b0, 1'b0,3'd0, 1'b0,3'd0,16'h0, 1'b0,3'd0,16'h0, 1'b0,1'b0,1'b0, 1'b1,3'd3,16'h1234, 8'h08,1'b0);
        add(1'b0, 1'b0,3'd0, 1'b0,3'd0,16'h0, 1'b0,3'd0,16'h0, 1'b0,1'b0,1'b0, 1'b0,3'd0,16'h0, 8'h00,1'b0);
        // Test 2: reset (restores A-first tie), reserve r1, r2, then A/B tie for 2 cycles
        add(1'b1, 1'b0,3'd0, 1'b0,3'd0,16'h0, 1'b0,3'd0,16'h0, 1'b0,1'b0,1'b0, 1'b0,3'd0,16'h0, 8'h00,1'b0);
        add(1'b0, 1'b1,3'd1, 1'b0,3'd0,16'h0, 1'b0,3'd0,16'h0, 1'b1,1'b0,1'b0, 1'b0,3'd0,16'h0, 8'h00,1'b0);
        add(1'b0, 1'b1,3'd2, 1'b0,3'd0,16'h0, 1'b0,3'd0,16'h0, 1'b1,1'b0,1'b0, 1'b0,3'd0,16'h0, 8'h02,1'b0);
`ifdef WB_ARB_FIXED_PRIO_EN
        add(1'b0, 1'b0,3'd0, 1'b1,3'd1,16'hAAAA, 1'b1,3'd2,16'hBBBB, 1'b0,1'b1,1'b0, 1'b0,3'd0,16'h0, 8'h06,1'b0);
        add(1'b0, 1'b0,3'd0, 1'b1,3'd1,16'hAAAA, 1'b1,3'd2,16'hBBBB, 1'b0,1'b1,1'b0, 1'b1,3'd1,16'hAAAA, 8'h06,1'b0);
        add(1'b0, 1'b0,3'd0, 1'b0,3'd0,16'h0, 1'b1,3'd2,16'hBBBB, 1'b0,1'b0,1'b1, 1'b1,3'd1,16'hAAAA, 8'h04,1'b0);
        add(1'b0, 1'b0,3'd0, 1'b0,3'd0,16'h0, 1'b0,3'd0,16'h0, 1'b0,1'b0,1'b0, 1'b1,3'd2,16'hBBBB, 8'h04,1'b0);
        add(1'b0, 1'b0,3'd0, 1'b0,3'd0,16'h0, 1'b0,3'd0,16'h0, 1'b0,1'b0,1'b0, 1'b0,3'd0,16'h0, 8'h00,1'b0);
`else
        add(1'b0, 1'b0,3'd0, 1'b1,3'd1,16'hAAAA, 1'b1,3'd2,16'hBBBB, 1'b0,1'b1,1'b0, 1'b0,3'd0,16'h0, 8'h06,1'b0);
        add(1'b0, 1'b0,3'd0, 1'b1,3'd1,16'hAAAA, 1'b1,3'd2,16'hBBBB, 1'b0,1'b0,1'b1, 1'b1,3'd1,16'hAAAA, 8'h06,1'b0);
        add(1'b0, 1'b0,3'd0, 1'b0,3'd0,16'h0, 1'b0,3'd0,16'h0, 1'b0,1'b0,1'b0, 1'b1,3'd2,16'hBBBB, 8'h04,1'b0);
        add(1'b0, 1'b0,3'd0, 1'b0,3'd0,16'h0, 1'b0,3'd0,16'h0, 1'b0,1'b0,1'b0, 1'b0,3'd0,16'h0, 8'h00,1'b0);
        add(1'b0, 1'b0,3'd0, 1'b0,3'd0,16'h0, 1'b0,3'd0,16'h0, 1'b0,1'b0,1'b0, 1'b0,3'd0,16'h0, 8'h00,1'b0);
`endif
        // Test 3: reissue of r5 during its own commit stalls one cycle
        add(1'b0, 1'b1,3'd5, 1'b0,3'd0,16'h0, 1'b0,3'd0,16'h0, 1'b1,1'b0,1'b0, 1'b0,3'd0,16'h0, 8'h00,1'b0);
        add(1'b0, 1'b0,3'd0, 1'b1,3'd5,16'h5555, 1'b0,3'd0,16'h0, 1'b0,1'b1,1'b0, 1'b0,3'd0,16'h0, 8'h20,1'b0);
        add(1'b0, 1'b1,3'd5, 1'b0,3'd0,16'h0, 1'b0,3'd0,16'h0, 1'b0,1'b0,1'b0, 1'b1,3'd5,16'h5555, 8'h20,1'b0);
        add(1'b0, 1'b1,3'd5, 1'b0,3'd0,16'h0, 1'b0,3'd0,16'h0, 1'b1,1'b0,1'b0, 1'b0,3'd0,16'h0, 8'h00,1'b0);
        add(1'b0, 1'b0,3'd0, 1'b0,3'd0,16'h0, 1'b0,3'd0,16'h0, 1'b0,1'b0,1'b0, 1'b0,3'd0,16'h0, 8'h20,1'b0);
        // Test 4: unreserved write to r7; reserve r7 on its commit edge (set wins)
        add(1'b0, 1'b0,3'd0, 1'b1,3'd7,16'h7777, 1'b0,3'd0,16'h0, 1'b0,1'b1,1'b0, 1'b0,3'd0,16'h0, 8'h20,1'b0);
        add(1'b0, 1'b1,3'd7, 1'b0,3'd0,16'h0, 1'b0,3'd0,16'h0, 1'b1,1'b0,1'b0, 1'b1,3'd7,16'h7777, 8'h20,1'b1);
        add(1'b0, 1'b0,3'd0, 1'b0,3'd0,16'h0, 1'b0,3'd0,16'h0, 1'b0,1'b0,1'b0, 1'b0,3'd0,16'h0, 8'hA0,1'b1);
        add(1'b0, 1'b0,3'd0, 1'b0,3'd0,16'h0, 1'b0,3'd0,16'h0, 1'b0,1'b0,1'b0, 1'b0,3'd0,16'h0, 8'hA0,1'b1);
        // Test 5: fill scoreboard to FF, reset with a grant in flight
        add(1'b0, 1'b1,3'd0, 1'b0,3'd0,16'h0, 1'b0,3'd0,16'h0, 1'b1,1'b0,1'b0, 1'b0,3'd0,16'h0, 8'hA0,1'b1);
        add(1'b0, 1'b1,3'd1, 1'b0,3'd0,16'h0, 1'b0,3'd0,16'h0, 1'b1,1'b0,1'b0, 1'b0,3'd0,16'h0, 8'hA1,1'b1);
        add(1'b0, 1'b1,3'd2, 1'b0,3'd0,16'h0, 1'b0,3'd0,16'h0, 1'b1,1'b0,1'b0, 1'b0,3'd0,16'h0, 8'hA3,1'b1);
        add(1'b0, 1'b1,3'd3, 1'b0,3'd0,16'h0, 1'b0,3'd0,16'h0, 1'b1,1'b0,1'b0, 1'b0,3'd0,16'h0, 8'hA7,1'b1);
        add(1'b0, 1'b1,3'd4, 1'b0,3'd0,16'h0, 1'b0,3'd0,16'h0, 1'b1,1'b0,1'b0, 1'b0,3'd0,16'h0, 8'hAF,1'b1);
        add(1'b0, 1'b1,3'd6, 1'b1,3'd0,16'h0F0F, 1'b0,3'd0,16'h0, 1'b1,1'b1,1'b0, 1'b0,3'd0,16'h0, 8'hBF,1'b1);
        add(1'b1, 1'b0,3'd0, 1'b1,3'd1,16'h1111, 1'b0,3'd0,16'h0, 1'b0,1'b1,1'b0, 1'b1,3'd0,16'h0F0F, 8'hFF,1'b1);
        add(1'b0, 1'b0,3'd0, 1'b1,3'd1,16'h1111, 1'b1,3'd2,16'h2222, 1'b0,1'b1,1'b0, 1'b0,3'd0,16'h0, 8'h00,1'b0);
        add(1'b0, 1'b0,3'd0, 1'b0,3'd0,16'h0, 1'b1,3'd2,16'h2222, 1'b0,1'b0,1'b1, 1'b1,3'd1,16'h1111, 8'h00,1'b1);
        add(1'b0, 1'b0,3'd0, 1'b0,3'd0,16'h0, 1'b0,3'd0,16'h0, 1'b0,1'b0,1'b0, 1'b1,3'd2,16'h2222, 8'h00,1'b1);
        add(1'b0, 1'b0,3'd0, 1'b0,3'd0,16'h0, 1'b0,3'd0,16'h0, 1'b0,1'b0,1'b0, 1'b0,3'd0,16'h0, 8'h00,1'b1);
        // Test 6: continuous A (r4) and B (r6) requests for 10 cycles
        for (int k = 0; k < 10; k++) begin
`ifdef WB_ARB_FIXED_PRIO_EN
            add(1'b0, 1'b0,3'd0, 1'b1,3'd4,16'hA0A0, 1'b1,3'd6,16'hB0B0, 1'b0,1'b1,1'b0,
                (k > 0), 3'd4, 16'hA0A0, 8'h00,1'b1);
`else
            add(1'b0, 1'b0,3'd0, 1'b1,3'd4,16'hA0A0, 1'b1,3'd6,16'hB0B0, 1'b0,(k % 2 == 0),(k % 2 == 1),
                (k > 0), (k % 2 == 1) ? 3'd4 : 3'd6, (k % 2 == 1) ? 16'hA0A0 : 16'hB0B0, 8'h00,1'b1);
`endif
        end
`ifdef WB_ARB_FIXED_PRIO_EN
        add(1'b0, 1'b0,3'd0, 1'b0,3'd0,16'h0, 1'b0,3'd0,16'h0, 1'b0,1'b0,1'b0, 1'b1,3'd4,16'hA0A0, 8'h00,1'b1);
`else
        add(1'b0, 1'b0,3'd0, 1'b0,3'd0,16'h0, 1'b0,3'd0,16'h0, 1'b0,1'b0,1'b0, 1'b1,3'd6,16'hB0B0, 8'h00,1'b1);
`endif
        add(1'b0, 1'b0,3'd0, 1'b0,3'd0,16'h0, 1'b0,3'd0,16'h0, 1'b0,1'b0,1'b0, 1'b0,3'd0,16'h0, 8'h00,1'b1);

        // ---- initial reset ----
        rst = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);

        // ---- apply table: drive after the edge, check at the falling edge ----
        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            rst = vecs[i].rst;
            iss_valid = vecs[i].iv; iss_addr = vecs[i].ia;
            a_valid = vecs[i].av; a_addr = vecs[i].aa; a_data = vecs[i].ad;
            b_valid = vecs[i].bv; b_addr = vecs[i].ba; b_data = vecs[i].bd;
            @(negedge clk);
            n_vec++;
            chk("iss_ready", i, 16'(iss_ready), 16'(vecs[i].eir));
            chk("a_ready",   i, 16'(a_ready),   16'(vecs[i].ear));
            chk("b_ready",   i, 16'(b_ready),   16'(vecs[i].ebr));
            chk("wr_en",     i, 16'(wr_en),     16'(vecs[i].ewe));
            if (vecs[i].ewe) begin
                chk("wr_addr", i, 16'(wr_addr), 16'(vecs[i].ewa));
                chk("wr_data", i, wr_data,      vecs[i].ewd);
            end
            chk("busy",      i, 16'(busy),      16'(vecs[i].ebusy));
            chk("wb_err",    i, 16'(wb_err),    16'(vecs[i].eerr));
            $display("vec %0d rst=%b iss=%b/%0d a=%b/%0d b=%b/%0d -> ir=%b ar=%b br=%b we=%b wa=%0d wd=%h busy=%h err=%b",
                     i, vecs[i].rst, vecs[i].iv, vecs[i].ia, vecs[i].av, vecs[i].aa, vecs[i].bv, vecs[i].ba,
                     iss_ready, a_ready, b_ready, wr_en, wr_addr, wr_data, busy, wb_err);
        end

        // ---- hand sequence: commit latency, busy releases two cycles after grant ----
        @(posedge clk); #1; rst = 1'b1; drive_idle();
        @(posedge clk); #1; rst = 1'b0; iss_valid = 1'b1; iss_addr = 3'd2;
        @(posedge clk); #1; drive_idle(); a_valid = 1'b1; a_addr = 3'd2; a_data = 16'h2BAD;
        @(negedge clk);
        n_vec++;
        chk("seq_a_ready", 100, 16'(a_ready), 16'h1);
        chk("seq_busy_set", 100, 16'(busy), 16'h0004);
        @(posedge clk); #1; drive_idle();
        cyc = 0; seen = 16'h0; seen_we = 1'b0; done = 1'b0;
        while (!done && cyc < 8) begin
            @(negedge clk);
            cyc++;
            if (wr_en) begin
                seen = wr_data;
                seen_we = 1'b1;
            end
            if (!busy[2]) done = 1'b1;
            else @(posedge clk);
        end
        n_vec++;
        chk("seq_release_seen", 101, 16'(done), 16'h1);
        chk("seq_release_cycles", 101, 16'(cyc), 16'd2);
        chk("seq_write_seen", 101, 16'(seen_we), 16'h1);
        chk("seq_write_data", 101, seen, 16'h2BAD);
        chk("seq_err", 101, 16'(wb_err), 16'h0);
        $display("seq release after %0d cycles, data=%h err=%b", cyc, seen, wb_err);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
